pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and stall controller for the 5-stage pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts load-use bubbles and flushes wrong-path instructions on a taken branch resolved in MEM. It freezes the pipeline while a multi-cycle data-memory access in MEM is outstanding, with timeout, and keeps saturating stall and flush statistics.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max cycles spent in MEM_WAIT before the access is abandoned (≥1).
- CNT_W, 16: width of statistics counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_id_rs  input  5  rs field of instruction in ID.
- if_id_rt  input  5  rt field of instruction in ID.
- if_id_uses_rt  input  1  ID instruction reads rt.
- id_ex_MemRead  input  1  instruction in EX is a load.
- id_ex_rt  input  5  load destination register in EX.
- ex_mem_Branch  input  1  instruction in MEM is a branch.
- ex_mem_zero  input  1  ALU zero flag latched in EX/MEM.
- ex_mem_MemRead  input  1  MEM-stage load.
- ex_mem_MemWrite  input  1  MEM-stage store.
- dmem_ready  input  1  data memory completes the access this cycle.
- dmem_req  output  1  data-memory access request.
- PCSrc  output  1  select branch target for PC.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- id_ex_bubble  output  1  zero control bits entering ID/EX.
- flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  synchronous clear of those registers.
- pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB.
- state  output  1  0=RUN, 1=MEM_WAIT.
- mem_err  output  1  sticky memory-timeout flag.
- stall_cnt  output  CNT_W  stall cycles, saturating.
- flush_cnt  output  CNT_W  taken-branch flushes, saturating.

## Operation
- Terms: access = ex_mem_MemRead | ex_mem_MemWrite. taken = ex_mem_Branch & ex_mem_zero.
- dmem_req = access, in both states.
- Memory hold, in RUN or MEM_WAIT: active when access & !dmem_ready and the timeout has not been hit. While active: pipe_hold=1, pc_write=0, if_id_write=0. PCSrc, all flushes and id_ex_bubble are forced to 0.
- RUN → MEM_WAIT: when the memory hold is active. Stay in RUN if dmem_ready is high in the same cycle; zero wait states means no stall.
- MEM_WAIT → RUN:
  - On dmem_ready: hold drops that cycle and the pipe advances.
  - On timeout: wait counter == MEM_TIMEOUT and !dmem_ready. Hold drops, mem_err sets, and the access is abandoned.
- mem_err is cleared only by reset.
- Taken branch, when no memory hold: PCSrc=1 and flush_if_id, flush_id_ex, flush_ex_mem all =1 for that cycle. pc_write=1, if_id_write=1. The load-use check is suppressed.
- Load-use, when no memory hold and no taken branch: triggers when id_ex_MemRead, id_ex_rt≠0, and (id_ex_rt==if_id_rs or (if_id_uses_rt and id_ex_rt==if_id_rt)). Response: pc_write=0, if_id_write=0, id_ex_bubble=1, for one cycle per detection.
- Otherwise: pc_write=1, if_id_write=1, all others 0.
- Priority: memory hold > taken branch > load-use > normal.
- stall_cnt increments on every cycle with pipe_hold | id_ex_bubble. flush_cnt increments on every taken-branch flush cycle. Both saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from inputs and state. state, the wait counter, mem_err and the statistics counters are registered.
- While reset is low, all outputs are 0, state=RUN and the wait counter is 0. Reset asserted mid-MEM_WAIT returns to RUN immediately and the pending access is dropped.
- Stall from access at cycle N, ready at N+k (k≥1):
  - pipe_hold high in cycles N..N+k-1; low in N+k.
  - state=MEM_WAIT from N+1 through N+k; RUN at N+k+1.
- Wait counter: 1 in cycle N+1, increments each MEM_WAIT cycle, cleared on exit.
- Timeout: hold lasts at most MEM_TIMEOUT cycles (N..N+MEM_TIMEOUT-1); released in N+MEM_TIMEOUT; mem_err=1 from N+MEM_TIMEOUT+1.
- A taken branch coincident with hold is acted on in the release cycle; the inputs are still held.
- Counters reflect an event at the edge following the event cycle.

## Test plan
- Load-use: id_ex_MemRead=1, id_ex_rt=5, if_id_rs=5 → one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt 0→1. Repeat with id_ex_rt=0 → no bubble.
- Taken branch: ex_mem_Branch=1, ex_mem_zero=1, plus a simultaneous load-use pattern → PCSrc=1, all three flushes=1, id_ex_bubble=0; flush_cnt=1. With ex_mem_zero=0 → no flush.
- Memory wait: MemRead=1, dmem_ready low for 3 cycles then high → pipe_hold high 3 cycles, MEM_WAIT 3 cycles, stall_cnt=3, mem_err=0. Zero-wait access → no hold.
- Timeout: MEM_TIMEOUT=4, dmem_ready never asserted → hold 4 cycles, release in 5th, mem_err=1 next edge and stays set.
- Reset mid-MEM_WAIT: reset low asynchronously → outputs 0, state=RUN without a clock edge; counters 0.
- Saturation: CNT_W=4, 20 load-use bubbles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline.
// It handles load-use bubbles, taken-branch flushes, and data-memory wait holds with a timeout.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_Branch,
  input  logic             ex_mem_zero,
  input  logic             ex_mem_MemRead,
  input  logic             ex_mem_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PCSrc,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pipe_hold,
  output logic             state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;

  logic out_en;
  logic access;
  logic taken;
  logic load_use;
  logic timeout_hit;
  logic mem_hold;

  // The reset input is active-low: combinational outputs are only driven while out of reset.
  assign out_en      = reset;
  assign access      = ex_mem_MemRead | ex_mem_MemWrite;
  assign taken       = ex_mem_Branch & ex_mem_zero;
  assign load_use    = id_ex_MemRead && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  assign timeout_hit = (state_q == MEM_WAIT) && (wait_q == WAIT_W'(MEM_TIMEOUT));
  assign mem_hold    = access & ~dmem_ready & ~timeout_hit;

  always_comb begin
    dmem_req     = 1'b0;
    PCSrc        = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pipe_hold    = 1'b0;
    if (out_en) begin
      dmem_req = access;
      if (mem_hold) begin
        pipe_hold = 1'b1;
      end else if (taken) begin
        PCSrc        = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
      end else if (load_use) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = mem_hold ? MEM_WAIT : RUN;
    wait_d    = mem_hold ? wait_q + WAIT_W'(1) : '0;
    mem_err_d = mem_err_q | (timeout_hit & access & ~dmem_ready);
    stall_d   = stall_q;
    flush_d   = flush_q;
    if ((pipe_hold | id_ex_bubble) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush_if_id && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign state     = state_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic if_id_uses_rt, id_ex_MemRead, ex_mem_Branch, ex_mem_zero;
  logic ex_mem_MemRead, ex_mem_MemWrite, dmem_ready;
  logic dmem_req, PCSrc, pc_write, if_id_write, id_ex_bubble;
  logic flush_if_id, flush_id_ex, flush_ex_mem, pipe_hold, state, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_rt(id_ex_rt),
    .ex_mem_Branch(ex_mem_Branch), .ex_mem_zero(ex_mem_zero),
    .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .PCSrc(PCSrc),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pipe_hold(pipe_hold), .state(state), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: how many consecutive cycles the current access has been held, plus sticky/stat values
  int  heldCycles = 0;
  int  mErr = 0, mStall = 0, mFlush = 0;
  bit  eHold, eBubble, eFlush;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkCycle();
    bit acc, taken, lu;
    int ePc, eIfId, eReq, eState;
    acc   = ex_mem_MemRead || ex_mem_MemWrite;
    taken = ex_mem_Branch && ex_mem_zero;
    lu    = id_ex_MemRead && id_ex_rt != 0 &&
            (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
    eHold = 0; eBubble = 0; eFlush = 0; ePc = 0; eIfId = 0; eReq = 0; eState = 0;
    if (!reset) begin
      heldCycles = 0; mErr = 0; mStall = 0; mFlush = 0;
    end else begin
      eReq   = acc;
      eState = (heldCycles > 0);
      if (acc && !dmem_ready && heldCycles < TO) eHold = 1;
      else if (taken) begin eFlush = 1; ePc = 1; eIfId = 1; end
      else if (lu) eBubble = 1;
      else begin ePc = 1; eIfId = 1; end
    end
    checkOutput("dmem_req", dmem_req, eReq);
    checkOutput("PCSrc", PCSrc, eFlush);
    checkOutput("pc_write", pc_write, ePc);
    checkOutput("if_id_write", if_id_write, eIfId);
    checkOutput("id_ex_bubble", id_ex_bubble, eBubble);
    checkOutput("flush_if_id", flush_if_id, eFlush);
    checkOutput("flush_id_ex", flush_id_ex, eFlush);
    checkOutput("flush_ex_mem", flush_ex_mem, eFlush);
    checkOutput("pipe_hold", pipe_hold, eHold);
    checkOutput("state", state, eState);
    checkOutput("mem_err", mem_err, mErr);
    checkOutput("stall_cnt", stall_cnt, mStall);
    checkOutput("flush_cnt", flush_cnt, mFlush);
  endtask

  // Apply the effect of the coming rising edge to the model
  task automatic modelAdvance();
    bit acc;
    if (!reset) return;
    acc = ex_mem_MemRead || ex_mem_MemWrite;
    if (acc && !dmem_ready && heldCycles == TO) mErr = 1;
    if (eHold || eBubble) mStall = (mStall + 1 > CMAX) ? CMAX : mStall + 1;
    if (eFlush) mFlush = (mFlush + 1 > CMAX) ? CMAX : mFlush + 1;
    heldCycles = eHold ? heldCycles + 1 : 0;
  endtask

  task automatic applyStimulus(input bit rstN, input int rs, input int rt, input bit usesRt,
                               input bit idMr, input int idRt, input bit br, input bit zero,
                               input bit mr, input bit mw, input bit rdy);
    @(negedge clk);
    reset = rstN;
    if_id_rs = 5'(rs); if_id_rt = 5'(rt); if_id_uses_rt = usesRt;
    id_ex_MemRead = idMr; id_ex_rt = 5'(idRt);
    ex_mem_Branch = br; ex_mem_zero = zero;
    ex_mem_MemRead = mr; ex_mem_MemWrite = mw; dmem_ready = rdy;
    #1;
    checkCycle();
    modelAdvance();
  endtask

  task automatic idle();
    applyStimulus(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic randomPhase(input int n, input int readyPct, input int accPct);
    for (int i = 0; i < n; i++) begin
      bit acc;
      acc = ($urandom_range(0, 99) < accPct);
      applyStimulus(1, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                    ($urandom_range(0, 99) < 50), $urandom_range(0, 3),
                    ($urandom_range(0, 99) < 30), 1'($urandom),
                    acc && 1'($urandom), acc && 1'($urandom) || (acc && 1'($urandom)),
                    ($urandom_range(0, 99) < readyPct));
    end
  endtask

  initial begin
    reset = 0;
    if_id_rs = 0; if_id_rt = 0; if_id_uses_rt = 0; id_ex_MemRead = 0; id_ex_rt = 0;
    ex_mem_Branch = 0; ex_mem_zero = 0; ex_mem_MemRead = 0; ex_mem_MemWrite = 0;
    dmem_ready = 0;

    doReset();

    // load-use with a real destination, then with r0
    applyStimulus(1, 5, 7, 0, 1, 5, 0, 0, 0, 0, 1);
    checkOutput("lu_bubble", id_ex_bubble, 1);
    idle();
    checkOutput("lu_stall_cnt", stall_cnt, 1);
    applyStimulus(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1);
    checkOutput("lu_r0_bubble", id_ex_bubble, 0);

    // taken branch overrides a simultaneous load-use; untaken branch does nothing
    applyStimulus(1, 5, 7, 0, 1, 5, 1, 1, 0, 0, 1);
    checkOutput("br_pcsrc", PCSrc, 1);
    checkOutput("br_no_bubble", id_ex_bubble, 0);
    idle();
    checkOutput("br_flush_cnt", flush_cnt, 1);
    applyStimulus(1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 1);
    checkOutput("br_untaken_flush", flush_if_id, 0);

    // three wait states
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("mw_hold", pipe_hold, 1);
    end
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 1);
    checkOutput("mw_release", pipe_hold, 0);
    checkOutput("mw_state_last", state, 1);
    idle();
    checkOutput("mw_stall_cnt", stall_cnt, 3);
    checkOutput("mw_state_run", state, 0);
    checkOutput("mw_no_err", mem_err, 0);
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("zero_wait_hold", pipe_hold, 0);

    // timeout: ready never comes
    doReset();
    for (int i = 0; i < TO; i++) applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("to_release", pipe_hold, 0);
    checkOutput("to_err_not_yet", mem_err, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput("to_err_sticky", mem_err, 1);
    end

    // asynchronous reset in the middle of a wait
    doReset();
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rst_pre_state", state, 1);
    #2 reset = 0;
    #1;
    checkCycle();
    checkOutput("rst_async_state", state, 0);
    checkOutput("rst_async_req", dmem_req, 0);
    idle();

    // saturation of the stall counter
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1, 9, 0, 0, 1, 9, 0, 0, 0, 0, 1);
    idle();
    checkOutput("sat_stall_cnt", stall_cnt, CMAX);

    // randomized traffic
    doReset();
    randomPhase(300, 60, 40);
    doReset();
    randomPhase(150, 10, 70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
